// File: rtl/uart_pkg.sv
// Shared UART constants, state encoding and helpers for the transmit and receive paths.
package uart_pkg;

    localparam int   DEFAULT_CLKS_PER_BIT = 217;
    localparam int   DATA_BITS            = 8;
    localparam logic IDLE_LEVEL           = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake into the transmitter: valid/ready, transfer on the edge where both are high.
interface uart_tx_if;
    import uart_pkg::*;

    // The source holds valid and data until it sees ready; a transfer completes
    // on the rising edge where valid && ready, and data is captured on that edge.
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/uart_tx.sv
// 8N1/8N2 UART transmitter, LSB first, registered line output.
// Optional even parity bit after the data bits when UART_TX_PARITY_EN is defined.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    uart_tx_if.slave   in_if,
    output logic       tx_serial,
    output logic       busy,
    output logic [2:0] dbg_state
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    localparam logic [2:0] IDLE   = ST_IDLE;
    localparam logic [2:0] START  = ST_START;
    localparam logic [2:0] DATA   = ST_DATA;
    localparam logic [2:0] STOP   = ST_STOP;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] PARITY = ST_PARITY;
`endif

    logic [2:0]           state_q, state_d;
    logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 tx_q, tx_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 bit_done;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    assign bit_done  = (clk_cnt_q == CNT_LAST);
    assign tx_serial = tx_q;
    assign busy      = busy_q;
    assign in_if.ready = ready_q;
    assign dbg_state = state_q;

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        tx_d      = tx_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                bit_cnt_d = '0;
                tx_d      = IDLE_LEVEL;
                if (in_if.valid && ready_q) begin
                    shreg_d = in_if.data;
`ifdef UART_TX_PARITY_EN
                    parity_d = even_parity(in_if.data);
`endif
                    state_d = START;
                    tx_d    = 1'b0;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                if (bit_done) begin
                    clk_cnt_d = '0;
                    state_d   = DATA;
                    tx_d      = shreg_q[0];
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    clk_cnt_d = '0;
                    shreg_d   = shreg_q >> 1;
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = parity_q;
`else
                        state_d = STOP;
                        tx_d    = IDLE_LEVEL;
`endif
                    end else begin
                        // shreg_q[1] becomes shreg_d[0] after this shift
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        tx_d      = shreg_q[1];
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    clk_cnt_d = '0;
                    state_d   = STOP;
                    tx_d      = IDLE_LEVEL;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
`endif
            STOP: begin
                // bit counter is reused to count stop bits
                if (bit_done) begin
                    clk_cnt_d = '0;
                    if (bit_cnt_q == STOP_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = IDLE;
                        tx_d      = IDLE_LEVEL;
                        ready_d   = 1'b1;
                        busy_d    = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                clk_cnt_d = '0;
                bit_cnt_d = '0;
                tx_d      = IDLE_LEVEL;
                ready_d   = 1'b1;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            tx_q      <= IDLE_LEVEL;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            tx_q      <= tx_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

endmodule
